// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N producers, bursts capped at MAX_BURST.
// Latency: grant registers 1 cycle after req; writes then flow 1 word/cycle; 1 dead IDLE cycle between bursts.
// Backpressure: fifo_full stalls the granted producer (grant held, no ack, no write); no timeout.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   req/req_data/req_last  per-producer valid, data slice [i*WIDTH +: WIDTH], end-of-packet
//   req_ack           combinational one-hot accept
//   grant             registered one-hot grant, zero when idle
//   fifo_we/fifo_data to FIFO write port; fifo_full from FIFO full flag
//   stall_count       saturating count of full-stalled BURST cycles when
//                     FIFO_WRITE_ARB_STALL_STATS_EN is defined, otherwise tied to 0
module fifo_write_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ack,
  output logic [N-1:0]         grant,
  output logic                 fifo_we,
  output logic [WIDTH-1:0]     fifo_data,
  input  logic                 fifo_full,
  output logic [15:0]          stall_count
);

  localparam int               PTR_W     = $clog2(N);
  localparam logic [PTR_W:0]   N_W       = (PTR_W+1)'(N);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N-1);
  localparam logic [7:0]       LAST_BEAT = 8'(MAX_BURST-1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     grant_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] g_idx, g_idx_nxt;
  logic [7:0]       burst_cnt, burst_cnt_nxt;
  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;
  logic             req_g, last_g, xfer;

  // grant is zero outside BURST, so these are automatically quiet in IDLE and during reset
  assign req_g   = |(grant & req);
  assign last_g  = |(grant & req_last);
  assign xfer    = req_g & ~fifo_full;
  assign fifo_we = xfer;
  assign req_ack = grant & {N{xfer}};

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) fifo_data = fifo_data | req_data[i*WIDTH +: WIDTH];
    end
  end

  // First requester at or after rr_ptr. Scanning from the far end down lets the
  // nearest candidate overwrite the others. Wrap is explicit so N need not be 2^k.
  always_comb begin
    logic [PTR_W:0] pos;
    pick_vld = 1'b0;
    pick_idx = '0;
    pos      = '0;
    for (int k = N-1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (req[pos[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = pos[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    g_idx_nxt     = g_idx;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt     = BURST;
          grant_nxt     = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          g_idx_nxt     = pick_idx;
          burst_cnt_nxt = '0;
        end
      end
      BURST: begin
        // withdraw, end-of-packet, or burst cap all release the grant on this edge
        if (!req_g || (xfer && (last_g || burst_cnt == LAST_BEAT))) begin
          state_nxt     = IDLE;
          grant_nxt     = '0;
          burst_cnt_nxt = '0;
          rr_ptr_nxt    = (g_idx == LAST_IDX) ? '0 : g_idx + 1'b1;
        end else if (xfer) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      g_idx     <= g_idx_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

`ifdef FIFO_WRITE_ARB_STALL_STATS_EN
  logic stall;
  assign stall = req_g & fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a packet-level reference model.
// Latency: model predicts outputs each cycle from inputs and its own owner/pointer bookkeeping.
// Backpressure: a behavioural FIFO of depth 16 with random reads drives fifo_full.
module tb_fifo_write_arbiter;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic           fifo_we;
  logic [W-1:0]   fifo_data;
  logic           fifo_full;
  logic [15:0]    stall_count;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .fifo_we(fifo_we), .fifo_data(fifo_data),
    .fifo_full(fifo_full), .stall_count(stall_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: who owns the port, where the next search starts, words taken this grant
  int          owner;
  int          ptr;
  int          nwords;
  int          stall_m;
  bit          pres  [N];
  logic [15:0] pdata [N];
  bit          plast [N];
  logic [15:0] fifo_q [$];
  bit          rand_en;
  int          rd_pct;

  function automatic logic [31:0] exp_stall();
`ifdef FIFO_WRITE_ARB_STALL_STATS_EN
    return 32'(stall_m);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    owner   = -1;
    ptr     = 0;
    nwords  = 0;
    stall_m = 0;
    for (int i = 0; i < N; i++) begin
      pres[i]  = 1'b0;
      pdata[i] = '0;
      plast[i] = 1'b0;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] e_grant, e_ack;
    logic         e_we;
    logic [15:0]  e_data;
    bit           rd;
    bit           found;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rand_en) begin
        if (!pres[i] && $urandom_range(3) == 0) begin
          pres[i]  = 1'b1;
          pdata[i] = 16'($urandom);
          plast[i] = ($urandom_range(3) == 0);
        end else if (pres[i] && owner == i && $urandom_range(19) == 0) begin
          pres[i] = 1'b0;
        end
      end
      req[i]            = pres[i];
      req_last[i]       = plast[i];
      req_data[i*W +: W] = pdata[i];
    end
    fifo_full = (fifo_q.size() >= DEPTH);
    rd = rand_en ? ($urandom_range(99) < rd_pct) : 1'b0;

    e_grant = '0;
    e_ack   = '0;
    e_we    = 1'b0;
    e_data  = '0;
    if (owner >= 0) begin
      e_grant[owner] = 1'b1;
      e_data         = pdata[owner];
      if (pres[owner] && !fifo_full) begin
        e_we          = 1'b1;
        e_ack[owner]  = 1'b1;
      end
    end
    #1;
    check("grant", 32'(grant), 32'(e_grant));
    check("req_ack", 32'(req_ack), 32'(e_ack));
    check("fifo_we", 32'(fifo_we), 32'(e_we));
    check("fifo_data", 32'(fifo_data), 32'(e_data));
    check("stall_count", 32'(stall_count), exp_stall());

    @(posedge clk);
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (e_we) fifo_q.push_back(e_data);

    if (owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && pres[(ptr + k) % N]) begin
          found  = 1'b1;
          owner  = (ptr + k) % N;
          nwords = 0;
        end
      end
    end else begin
      if (pres[owner] && fifo_full && stall_m < 65535) stall_m++;
      if (!pres[owner]) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end else if (e_we) begin
        nwords++;
        pres[owner] = 1'b0;
        if (plast[owner] || nwords == MB) begin
          ptr   = (owner + 1) % N;
          owner = -1;
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    rand_en   = 1'b0;
    rd_pct    = 50;
    model_reset();
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_we", 32'(fifo_we), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_stall", 32'(stall_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    rand_en = 1'b1;
    rd_pct  = 30;
    for (int c = 0; c < 1200; c++) cycle();
    rd_pct  = 75;
    for (int c = 0; c < 1200; c++) cycle();
    rd_pct  = 100;
    for (int c = 0; c < 600; c++) cycle();

    // directed: async reset mid-burst
    rand_en = 1'b0;
    for (int i = 0; i < N; i++) pres[i] = 1'b0;
    fifo_q.delete();
    cycle();
    cycle();
    pres[1]  = 1'b1;
    pdata[1] = 16'h0A01;
    plast[1] = 1'b0;
    cycle();
    cycle();
    pres[1]  = 1'b1;
    pdata[1] = 16'h0A02;
    @(negedge clk);
    req      = 4'b0010;
    req_data[1*W +: W] = 16'h0A02;
    #1;
    check("pre_rst_we", 32'(fifo_we), 32'd1);
    #1;
    rst = 1'b0;
    req = '0;
    #1;
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_ack", 32'(req_ack), 32'd0);
    check("arst_we", 32'(fifo_we), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    pres[0]  = 1'b1;
    pdata[0] = 16'hB000;
    pres[3]  = 1'b1;
    pdata[3] = 16'hB003;
    cycle();
    cycle();
    check("post_rst_winner", 32'(grant), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
